// File: rtl/stream_mux_pkg.sv
// rtl/stream_mux_pkg.sv - shared mode encodings and channel slicing helper for stream_mux_rr
package stream_mux_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  localparam int MAX_CH    = 32;
  localparam int MAX_WIDTH = 64;
  localparam int MAX_FLAT  = MAX_CH * MAX_WIDTH;

  // Callers zero-extend their flat bus to MAX_FLAT and keep the low WIDTH bits.
  function automatic logic [MAX_WIDTH-1:0] ch_slice(input logic [MAX_FLAT-1:0] data,
                                                    input int i, input int width);
    logic [MAX_FLAT-1:0] shifted;
    shifted = data >> (i * width);
    return shifted[MAX_WIDTH-1:0];
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin arbiter using a double-width masked priority search
module rr_arbiter #(
  parameter int NUM_CH = 12,
  parameter int SEL_W  = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [SEL_W-1:0]  ptr,
  output logic [NUM_CH-1:0] gnt,
  output logic [SEL_W-1:0]  gnt_idx,
  output logic              any_gnt
);

  logic [2*NUM_CH-1:0] mask2;
  logic [2*NUM_CH-1:0] masked;
  int                  start;

  // The upper copy of req is fully unmasked, so any pending request is always found.
  always_comb begin
    start   = (int'(ptr) >= NUM_CH - 1) ? 0 : int'(ptr) + 1;
    mask2   = '0;
    for (int k = 0; k < 2 * NUM_CH; k++) begin
      mask2[k] = (k >= start);
    end
    masked  = {req, req} & mask2;
    any_gnt = 1'b0;
    gnt_idx = '0;
    for (int k = 0; k < 2 * NUM_CH; k++) begin
      if (!any_gnt && masked[k]) begin
        any_gnt = 1'b1;
        gnt_idx = SEL_W'(k % NUM_CH);
      end
    end
    gnt = any_gnt ? (NUM_CH'(1) << gnt_idx) : '0;
  end

endmodule

// File: rtl/stream_mux_rr.sv
// rtl/stream_mux_rr.sv - registered N-channel stream mux with fixed-select and round-robin modes
module stream_mux_rr #(
  parameter int WIDTH  = 16,
  parameter int NUM_CH = 12,
  parameter int SEL_W  = $clog2(NUM_CH)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    mode,
  input  logic [SEL_W-1:0]        sel,
  input  logic [NUM_CH*WIDTH-1:0] in_data,
  input  logic [NUM_CH-1:0]       in_valid,
  output logic [NUM_CH-1:0]       in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [SEL_W-1:0]        out_ch,
  output logic                    sel_err
);

  import stream_mux_pkg::*;

  logic                 load_en;
  logic                 sel_legal;
  logic                 any_grant;
  logic                 arb_any;
  logic [NUM_CH-1:0]    fix_gnt;
  logic [NUM_CH-1:0]    arb_gnt;
  logic [NUM_CH-1:0]    grant;
  logic [SEL_W-1:0]     arb_idx;
  logic [SEL_W-1:0]     grant_idx;
  logic [SEL_W-1:0]     rr_ptr;
  logic [MAX_WIDTH-1:0] word_full;
  logic [WIDTH-1:0]     word;

  rr_arbiter #(
    .NUM_CH (NUM_CH),
    .SEL_W  (SEL_W)
  ) u_arb (
    .req     (in_valid),
    .ptr     (rr_ptr),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx),
    .any_gnt (arb_any)
  );

  always_comb begin
    load_en   = !out_valid || out_ready;
    sel_legal = int'(sel) < NUM_CH;
    fix_gnt   = '0;
    if (sel_legal) begin
      fix_gnt[sel] = in_valid[sel];
    end
    if (mode == MODE_RR) begin
      grant     = arb_gnt;
      grant_idx = arb_idx;
      any_grant = arb_any;
    end else begin
      grant     = fix_gnt;
      grant_idx = sel;
      any_grant = |fix_gnt;
    end
    // Held low during reset so nothing is accepted while the output register is cleared.
    in_ready  = rst_n ? (grant & {NUM_CH{load_en}}) : '0;
    word_full = ch_slice(MAX_FLAT'(in_data), int'(grant_idx), WIDTH);
    word      = word_full[WIDTH-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      sel_err   <= 1'b0;
      rr_ptr    <= SEL_W'(NUM_CH - 1);
    end else begin
      sel_err <= (mode == MODE_FIXED) && !sel_legal;
      if (load_en) begin
        if (any_grant) begin
          out_valid <= 1'b1;
          out_data  <= word;
          out_ch    <= grant_idx;
          if (mode == MODE_RR) begin
            rr_ptr <= grant_idx;
          end
        end else begin
          out_valid <= 1'b0;
          out_data  <= '0;
          out_ch    <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_stream_mux_rr.sv
// tb/tb_stream_mux_rr.sv - directed and randomized self-checking bench for stream_mux_rr
module tb_stream_mux_rr;

  localparam int N  = 12;
  localparam int W  = 16;
  localparam int SW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          mode = 1'b0;
  logic [SW-1:0] sel = '0;
  logic [N*W-1:0] in_data = '0;
  logic [N-1:0]  in_valid = '0;
  logic [N-1:0]  in_ready;
  logic [W-1:0]  out_data;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [SW-1:0] out_ch;
  logic          sel_err;

  int checks = 0;
  int errors = 0;

  bit            m_valid;
  logic [W-1:0]  m_data;
  int            m_ch;
  bit            m_err;
  int            m_last;

  int seq4[4] = '{0, 5, 11, 0};

  stream_mux_rr #(.WIDTH(W), .NUM_CH(N), .SEL_W(SW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode      (mode),
    .sel       (sel),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ch    (out_ch),
    .sel_err   (sel_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] word_of(input int c);
    return in_data[c*W +: W];
  endfunction

  function automatic void set_ch(input int c, input logic [W-1:0] w);
    in_data[c*W +: W] = w;
  endfunction

  // Reference arbitration: fixed select, or first valid channel after the last RR winner.
  function automatic int model_grant();
    if (mode) begin
      for (int off = 1; off <= N; off++) begin
        if (in_valid[(m_last + off) % N]) return (m_last + off) % N;
      end
      return -1;
    end
    if (int'(sel) < N && in_valid[sel]) return int'(sel);
    return -1;
  endfunction

  task automatic cycle(input string tag);
    int           g;
    bit           load;
    logic [N-1:0] er;
    logic [W-1:0] nw;
    @(negedge clk);
    chk({tag, "_valid"}, 32'(out_valid), 32'(m_valid));
    chk({tag, "_data"}, 32'(out_data), 32'(m_data));
    if (m_valid) chk({tag, "_ch"}, 32'(out_ch), 32'(m_ch));
    chk({tag, "_err"}, 32'(sel_err), 32'(m_err));
    g    = model_grant();
    load = !m_valid || out_ready;
    er   = (g >= 0 && load) ? (N'(1) << g) : '0;
    nw   = (g >= 0) ? word_of(g) : '0;
    chk({tag, "_in_ready"}, 32'(in_ready), 32'(er));
    @(posedge clk);
    if (load) begin
      if (g >= 0) begin
        m_valid = 1'b1;
        m_data  = nw;
        m_ch    = g;
        if (mode) m_last = g;
      end else begin
        m_valid = 1'b0;
        m_data  = '0;
        m_ch    = 0;
      end
    end
    m_err = !mode && (int'(sel) >= N);
    #1;
  endtask

  task automatic apply_reset(input string tag);
    rst_n = 1'b0;
    #2;
    chk({tag, "_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_data"}, 32'(out_data), 32'd0);
    chk({tag, "_err"}, 32'(sel_err), 32'd0);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    m_valid = 1'b0;
    m_data  = '0;
    m_ch    = 0;
    m_err   = 1'b0;
    m_last  = N - 1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #3;
    apply_reset("rst0");

    // Fixed select of channel 3.
    mode = 1'b0; sel = 4'd3; in_valid = 12'h008; set_ch(3, 16'hBEEF); out_ready = 1'b1;
    #1;
    chk("t1_in_ready", 32'(in_ready), 32'h008);
    cycle("t1");
    chk("t1_out_valid", 32'(out_valid), 32'd1);
    chk("t1_out_data", 32'(out_data), 32'hBEEF);
    chk("t1_out_ch", 32'(out_ch), 32'd3);

    // Illegal selects.
    sel = 4'd12; in_valid = '1;
    cycle("t2a");
    chk("t2_err", 32'(sel_err), 32'd1);
    chk("t2_valid", 32'(out_valid), 32'd0);
    chk("t2_data", 32'(out_data), 32'd0);
    sel = 4'd13;
    for (int k = 0; k < 3; k++) begin
      cycle("t2b");
      chk("t2_err_hold", 32'(sel_err), 32'd1);
    end
    sel = 4'd0;
    cycle("t2c");
    chk("t2_err_clear", 32'(sel_err), 32'd0);

    // Round-robin over all channels.
    mode = 1'b1;
    for (int c = 0; c < N; c++) set_ch(c, W'(c));
    in_valid = '1;
    for (int i = 0; i <= N; i++) begin
      cycle("t3");
      chk("t3_rr_ch", 32'(out_ch), 32'(i % N));
      chk("t3_rr_data", 32'(out_data), 32'(i % N));
    end

    // Sparse round-robin with wrap-around.
    apply_reset("rst1");
    mode = 1'b1; in_valid = 12'h821;
    for (int i = 0; i < 4; i++) begin
      cycle("t4");
      chk("t4_rr_ch", 32'(out_ch), 32'(seq4[i]));
    end

    // Stall hold and release.
    mode = 1'b0; sel = 4'd2; in_valid = 12'h004; set_ch(2, 16'h1234); out_ready = 1'b1;
    cycle("t5a");
    chk("t5_loaded", 32'(out_data), 32'h1234);
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      sel = SW'(k + 5); in_valid = '1;
      for (int c = 0; c < N; c++) set_ch(c, W'($urandom));
      #1;
      chk("t5_stall_ready", 32'(in_ready), 32'd0);
      cycle("t5b");
      chk("t5_hold_data", 32'(out_data), 32'h1234);
      chk("t5_hold_ch", 32'(out_ch), 32'd2);
    end
    out_ready = 1'b1; sel = 4'd4; in_valid = 12'h010; set_ch(4, 16'h5678);
    cycle("t5c");
    chk("t5_next_data", 32'(out_data), 32'h5678);
    chk("t5_next_ch", 32'(out_ch), 32'd4);
    in_valid = '0;
    cycle("t5d");
    chk("t5_no_dup", 32'(out_valid), 32'd0);

    // Reset mid-stream.
    mode = 1'b1; in_valid = '1;
    cycle("t6a");
    cycle("t6b");
    in_valid = 12'h0F0;
    apply_reset("rst2");
    cycle("t6c");
    chk("t6_first_rr", 32'(out_ch), 32'd4);

    // Randomized traffic against the reference model.
    for (int n = 0; n < 400; n++) begin
      mode      = 1'($urandom_range(0, 1));
      sel       = ($urandom_range(0, 9) == 0) ? SW'($urandom_range(12, 15)) : SW'($urandom_range(0, 11));
      in_valid  = N'($urandom);
      for (int c = 0; c < N; c++) set_ch(c, W'($urandom));
      out_ready = ($urandom_range(0, 3) != 0);
      cycle("rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
